// File: rtl/uart_rx_param.sv
// uart_rx_param -- oversampling UART receiver with valid/ready output.
//
// Each bit is sampled on a divided-down tick (16 ticks per bit). Its value is
// the majority of samples 7, 8 and 9. A completed frame is presented on rx_data
// together with its error flags.
//
// Output handshake: rx_valid high means rx_data/frame_err/parity_err hold an
// unconsumed frame and stay stable. The frame is consumed on a rising sysclk
// edge where rx_valid && rx_ready; rx_valid drops on the following cycle
// unless a new frame completes on that same edge. A frame that completes while
// rx_valid && !rx_ready is dropped, and this sets the sticky overrun flag.
//
// Ports:
//   sysclk      - only clock, rising edge
//   reset       - asynchronous, active-high
//   UART_RX     - asynchronous serial input (idle high after RX_INVERT)
//   enable      - receiver enable; low aborts any partial frame
//   rx_data     - last received word (LSB first on the line)
//   rx_valid    - rx_data holds an unconsumed frame
//   rx_ready    - consumer accepts rx_data
//   busy        - FSM is outside IDLE
//   frame_err   - a stop bit of the held frame was sampled low
//   parity_err  - parity check of the held frame failed
//   overrun     - sticky: a completed frame was dropped
//   state_dbg   - current FSM state encoding, for observation
module uart_rx_param #(
    parameter int CLK_HZ    = 100000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int RX_INVERT = 0
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 UART_RX,
    input  logic                 enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic [2:0]           state_dbg
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic             INV       = (RX_INVERT != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t                state;
    logic                  sync0, sync1, rx_prev;
    logic [DIV_W-1:0]      div_cnt;
    logic [3:0]            s_cnt;
    logic [3:0]            bit_cnt;
    logic [3:0]            hi_cnt;
    logic                  stop_cnt;
    logic                  samp7, samp8;
    logic [DATA_BITS-1:0]  shreg;
    logic                  perr_acc, ferr_acc;

    logic tick, start_go, in_frame, mid, bit_end, maj, fe_now, complete;

    assign tick     = (div_cnt == DIV_LAST);
    assign start_go = (state == ST_IDLE) && enable && rx_prev && !sync1;
    assign in_frame = (state == ST_START) || (state == ST_DATA) ||
                      (state == ST_PARITY) || (state == ST_STOP);
    assign mid      = tick && (s_cnt == 4'd9);
    assign bit_end  = tick && (s_cnt == 4'd15);
    // Samples 7 and 8 are registered; sample 9 is the live synchronised line.
    assign maj      = (samp7 & samp8) | (samp7 & sync1) | (samp8 & sync1);
    assign fe_now   = ferr_acc | ~maj;
    assign complete = enable && (state == ST_STOP) && mid && (stop_cnt == LAST_STOP);

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // Two-flop synchroniser plus one extra stage for falling-edge detection.
    // Reset to the idle level so release never looks like a start edge.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync0   <= 1'b1;
            sync1   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync0   <= UART_RX ^ INV;
            sync1   <= sync0;
            rx_prev <= sync1;
        end
    end

    // Tick divider; realigned to the start edge so sample 8 lands mid-bit.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (start_go || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            s_cnt      <= 4'd0;
            bit_cnt    <= 4'd0;
            hi_cnt     <= 4'd0;
            stop_cnt   <= 1'b0;
            samp7      <= 1'b1;
            samp8      <= 1'b1;
            shreg      <= '0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Output register. A completion on a handshake edge reloads the
            // frame and keeps rx_valid high; overrun is then left unchanged.
            if (complete) begin
                if (rx_valid && !rx_ready) begin
                    overrun <= 1'b1;
                end else begin
                    rx_data    <= shreg;
                    frame_err  <= fe_now;
                    parity_err <= perr_acc;
                    rx_valid   <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            // Per-bit tick counter and mid-bit sample capture.
            if (in_frame && tick) begin
                s_cnt <= s_cnt + 4'd1;
                if (s_cnt == 4'd7) samp7 <= sync1;
                if (s_cnt == 4'd8) samp8 <= sync1;
            end

            if (!enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_go) begin
                            state    <= ST_START;
                            s_cnt    <= 4'd0;
                            perr_acc <= 1'b0;
                            ferr_acc <= 1'b0;
                        end
                    end
                    ST_START: begin
                        if (mid && maj) begin
                            state <= ST_IDLE;   // glitch: start bit not held low
                        end else if (bit_end) begin
                            state   <= ST_DATA;
                            bit_cnt <= 4'd0;
                        end
                    end
                    ST_DATA: begin
                        if (mid) begin
                            shreg <= {maj, shreg[DATA_BITS-1:1]};
                        end
                        if (bit_end) begin
                            if (bit_cnt == LAST_DATA) begin
                                state    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                                stop_cnt <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (mid) begin
                            // Even: error when overall XOR is 1. Odd: when it is 0.
                            perr_acc <= (PARITY == 1) ? (^shreg ^ maj) : ~(^shreg ^ maj);
                        end
                        if (bit_end) begin
                            state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (mid) begin
                            ferr_acc <= fe_now;
                            if (stop_cnt == LAST_STOP) begin
                                state  <= fe_now ? ST_BREAK : ST_IDLE;
                                hi_cnt <= 4'd0;
                            end
                        end else if (bit_end) begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        // Wait for a full bit time of continuous idle line.
                        if (tick) begin
                            if (!sync1) begin
                                hi_cnt <= 4'd0;
                            end else if (hi_cnt == 4'd15) begin
                                state <= ST_IDLE;
                            end else begin
                                hi_cnt <= hi_cnt + 4'd1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int BIT_CYC = 160;   // 1.6 MHz / 10 kbaud

    logic       sysclk = 1'b0;
    logic       reset;
    logic       line_a, line_b;
    logic       enable;
    logic       rx_ready;
    logic [7:0] rx_data_a, rx_data_b;
    logic       rx_valid_a, rx_valid_b;
    logic       busy_a, busy_b;
    logic       frame_err_a, frame_err_b;
    logic       parity_err_a, parity_err_b;
    logic       overrun_a, overrun_b;
    logic [2:0] state_a, state_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected frames as {data, parity_err, frame_err}.
    logic [9:0] exp_q_a[$];
    logic [9:0] exp_q_b[$];

    typedef struct {
        int         sel;       // 0: 8N1 receiver, 1: 8E1 receiver
        logic [7:0] data;
        logic       pbit;
        logic       exp_perr;
    } vec_t;
    vec_t vecs[10];

    always #5 sysclk = ~sysclk;

    uart_rx_param #(.CLK_HZ(1600000), .BAUD(10000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .RX_INVERT(0)) dut_a (
        .sysclk(sysclk), .reset(reset), .UART_RX(line_a), .enable(enable),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready),
        .busy(busy_a), .frame_err(frame_err_a), .parity_err(parity_err_a),
        .overrun(overrun_a), .state_dbg(state_a)
    );

    uart_rx_param #(.CLK_HZ(1600000), .BAUD(10000), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .RX_INVERT(0)) dut_b (
        .sysclk(sysclk), .reset(reset), .UART_RX(line_b), .enable(enable),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready),
        .busy(busy_b), .frame_err(frame_err_b), .parity_err(parity_err_b),
        .overrun(overrun_b), .state_dbg(state_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic b);
        if (sel == 0) line_a = b;
        else          line_b = b;
    endtask

    task automatic drive_bit(input int sel, input logic b, input int n);
        set_line(sel, b);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic use_par,
                              input logic pbit, input int stop_cyc, input logic stop_val);
        drive_bit(sel, 1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], BIT_CYC);
        if (use_par) drive_bit(sel, pbit, BIT_CYC);
        drive_bit(sel, stop_val, stop_cyc);
        set_line(sel, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic set_vec(input int i, input int sel, input logic [7:0] d,
                           input logic pbit, input logic perr);
        vecs[i].sel      = sel;
        vecs[i].data     = d;
        vecs[i].pbit     = pbit;
        vecs[i].exp_perr = perr;
    endtask

    // Scoreboards: every new rx_valid must match the oldest queued frame.
    initial begin : mon_a
        logic       prev;
        logic [9:0] e;
        prev = 1'b0;
        forever begin
            @(negedge sysclk);
            if (rx_valid_a && !prev) begin
                if (exp_q_a.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_a_unexpected: got data %02h, expected no frame", rx_data_a);
                end else begin
                    e = exp_q_a.pop_front();
                    check("frame_a", {6'b0, rx_data_a, parity_err_a, frame_err_a}, {6'b0, e});
                end
            end
            prev = rx_valid_a;
        end
    end

    initial begin : mon_b
        logic       prev;
        logic [9:0] e;
        prev = 1'b0;
        forever begin
            @(negedge sysclk);
            if (rx_valid_b && !prev) begin
                if (exp_q_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_b_unexpected: got data %02h, expected no frame", rx_data_b);
                end else begin
                    e = exp_q_b.pop_front();
                    check("frame_b", {6'b0, rx_data_b, parity_err_b, frame_err_b}, {6'b0, e});
                end
            end
            prev = rx_valid_b;
        end
    end

    initial begin : main
        logic [7:0] r;
        logic       pb;

        // ---------------- clock / reset ----------------
        reset    = 1'b1;
        line_a   = 1'b1;
        line_b   = 1'b1;
        enable   = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check("rst_data",  {8'b0, rx_data_a}, 16'h0);
        check("rst_flags", {rx_valid_a, busy_a, frame_err_a, parity_err_a, overrun_a}, 16'h0);
        check("rst_flags_b", {rx_valid_b, busy_b, frame_err_b, parity_err_b, overrun_b}, 16'h0);
        check("rst_state", {state_a, state_b}, 16'h0);
        @(posedge sysclk);
        #1 reset = 1'b0;
        idle(20);

        // ---------------- 0xA5 8N1, single-cycle rx_valid ----------------
        exp_q_a.push_back({8'hA5, 1'b0, 1'b0});
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b0, BIT_CYC, 1'b1);
            begin : watch_a5
                int k;
                k = 0;
                while (!rx_valid_a && k < 2000) begin
                    @(negedge sysclk);
                    k++;
                end
                check("a5_valid_seen", rx_valid_a, 1'b1);
                check("a5_busy_low", busy_a, 1'b0);
                @(negedge sysclk);
                check("a5_valid_pulse", rx_valid_a, 1'b0);
            end
        join
        idle(20);
        check("a5_drained", exp_q_a.size(), 0);

        // ---------------- table-driven frames ----------------
        set_vec(0, 0, 8'h00, 1'b0, 1'b0);
        set_vec(1, 0, 8'hFF, 1'b0, 1'b0);
        set_vec(2, 1, 8'h07, 1'b0, 1'b1);
        set_vec(3, 1, 8'h07, 1'b1, 1'b0);
        set_vec(4, 1, 8'h00, 1'b0, 1'b0);
        set_vec(5, 1, 8'hFF, 1'b1, 1'b1);
        set_vec(6, 1, 8'h80, 1'b1, 1'b0);
        set_vec(7, 0, 8'h01, 1'b0, 1'b0);
        r = 8'($urandom_range(0, 255));
        set_vec(8, 0, r, 1'b0, 1'b0);
        r  = 8'($urandom_range(0, 255));
        pb = 1'($urandom_range(0, 1));
        set_vec(9, 1, r, pb, ^r ^ pb);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].sel == 0) exp_q_a.push_back({vecs[i].data, 1'b0, 1'b0});
            else                  exp_q_b.push_back({vecs[i].data, vecs[i].exp_perr, 1'b0});
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].sel == 1, vecs[i].pbit, BIT_CYC, 1'b1);
            idle(20);
            check("vec_drained", exp_q_a.size() + exp_q_b.size(), 0);
        end

        // ---------------- glitch rejection ----------------
        drive_bit(0, 1'b0, 40);
        set_line(0, 1'b1);
        idle(10);
        check("glitch_busy", busy_a, 1'b1);
        idle(100);
        check("glitch_idle", busy_a, 1'b0);
        check("glitch_no_valid", rx_valid_a, 1'b0);
        exp_q_a.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(0, 8'h3C, 1'b0, 1'b0, BIT_CYC, 1'b1);
        idle(20);
        check("glitch_next_drained", exp_q_a.size(), 0);

        // ---------------- framing error and break ----------------
        exp_q_a.push_back({8'h0F, 1'b0, 1'b1});
        send_frame(0, 8'h0F, 1'b0, 1'b0, 2 * BIT_CYC, 1'b0);
        check("break_busy_at_release", busy_a, 1'b1);
        check("break_ferr_held", frame_err_a, 1'b1);
        idle(100);
        check("break_busy_mid", busy_a, 1'b1);
        idle(100);
        check("break_busy_done", busy_a, 1'b0);
        exp_q_a.push_back({8'h55, 1'b0, 1'b0});
        send_frame(0, 8'h55, 1'b0, 1'b0, BIT_CYC, 1'b1);
        idle(20);
        check("break_next_ferr", frame_err_a, 1'b0);
        check("break_drained", exp_q_a.size(), 0);

        // ---------------- overrun ----------------
        rx_ready = 1'b0;
        exp_q_a.push_back({8'h11, 1'b0, 1'b0});
        send_frame(0, 8'h11, 1'b0, 1'b0, BIT_CYC, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b0, BIT_CYC, 1'b1);
        idle(20);
        check("ovr_data", {8'b0, rx_data_a}, 16'h11);
        check("ovr_valid", rx_valid_a, 1'b1);
        check("ovr_flag", overrun_a, 1'b1);

        // Drop enable mid-frame: FSM aborts, held frame and flags untouched.
        drive_bit(0, 1'b0, BIT_CYC);
        drive_bit(0, 1'b1, 80);
        check("en_busy_before", busy_a, 1'b1);
        enable = 1'b0;
        @(posedge sysclk);
        @(negedge sysclk);
        check("en_abort_busy", busy_a, 1'b0);
        check("en_keep_out", {rx_data_a, rx_valid_a, overrun_a}, {8'h11, 1'b1, 1'b1});
        idle(5);
        enable = 1'b1;
        idle(300);
        check("en_no_frame", {rx_data_a, rx_valid_a, overrun_a, busy_a}, {8'h11, 1'b1, 1'b1, 1'b0});

        @(posedge sysclk);
        #1 rx_ready = 1'b1;
        @(negedge sysclk);
        check("hs_before", {rx_valid_a, overrun_a}, 2'b11);
        @(negedge sysclk);
        check("hs_after", {rx_valid_a, overrun_a}, 2'b00);
        idle(20);

        // ---------------- reset mid-frame ----------------
        rx_ready = 1'b0;
        exp_q_a.push_back({8'h5A, 1'b0, 1'b0});
        send_frame(0, 8'h5A, 1'b0, 1'b0, BIT_CYC, 1'b1);
        idle(20);
        check("rstmid_pre_valid", rx_valid_a, 1'b1);
        drive_bit(0, 1'b0, BIT_CYC);       // start
        drive_bit(0, 1'b1, BIT_CYC);       // 0x81 bit 0
        drive_bit(0, 1'b0, BIT_CYC);       // bit 1
        drive_bit(0, 1'b0, BIT_CYC);       // bit 2
        drive_bit(0, 1'b0, 80);            // half of bit 3
        @(negedge sysclk);
        check("rstmid_pre_busy", busy_a, 1'b1);
        reset = 1'b1;
        #1;
        check("rstmid_data", {8'b0, rx_data_a}, 16'h0);
        check("rstmid_flags", {rx_valid_a, busy_a, frame_err_a, parity_err_a, overrun_a}, 16'h0);
        @(posedge sysclk);
        #1 reset = 1'b0;
        rx_ready = 1'b1;
        set_line(0, 1'b1);
        idle(2 * BIT_CYC);
        exp_q_a.push_back({8'h81, 1'b0, 1'b0});
        send_frame(0, 8'h81, 1'b0, 1'b0, BIT_CYC, 1'b1);
        idle(20);
        check("rstmid_drained", exp_q_a.size(), 0);

        // ---------------- report ----------------
        idle(20);
        check("final_queues_empty", exp_q_a.size() + exp_q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..8.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame, 1 or 2.
REQ-006 SHALL have parameter RX_INVERT, default 0; when 1, UART_RX is inverted before use.
REQ-007 SHALL have port sysclk, input, 1, the only clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port UART_RX, input, 1, asynchronous serial line, idle high after optional inversion.
REQ-010 SHALL have port enable, input, 1, receiver enable.
REQ-011 SHALL have port rx_data, output, DATA_BITS, last received data word, LSB first on the line.
REQ-012 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed frame.
REQ-013 SHALL have port rx_ready, input, 1, consumer accepts rx_data when rx_valid is high.
REQ-014 SHALL have port busy, output, 1, high whenever the FSM is outside IDLE.
REQ-015 SHALL have ports frame_err, parity_err, output, 1 each, error status of the frame held in rx_data.
REQ-016 SHALL have port overrun, output, 1, sticky: a completed frame was dropped.

Function
REQ-017 SHALL pass UART_RX through a 2-flop synchroniser before any other use.
REQ-018 SHALL generate a one-cycle sample tick every DIV = max(1, CLK_HZ/(BAUD*16)) cycles, integer floor, giving 16 ticks per bit.
REQ-019 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-020 SHALL, in IDLE with enable high, move to START on a synchronised high-to-low edge and restart the tick divider and sample counter in that cycle.
REQ-021 SHALL take each bit value as the majority of samples 7, 8 and 9 of that bit's 16 ticks.
REQ-022 SHALL return to IDLE from START, without any output change, if the start-bit majority is 1 (glitch rejection).
REQ-023 SHALL shift in DATA_BITS bits, LSB first, then enter PARITY if PARITY is nonzero, otherwise STOP.
REQ-024 SHALL set parity_err when the XOR of the data bits and the parity bit is 1 for even parity, or 0 for odd parity.
REQ-025 SHALL check STOP_BITS stop bits; any stop bit sampled 0 sets frame_err.
REQ-026 SHALL complete the frame at the mid-sample of the last stop bit, with rx_valid high exactly 1 cycle later.
REQ-027 SHALL go to BREAK after a frame_err and stay there until the synchronised line reads 1 for 16 consecutive ticks, then IDLE.
REQ-028 SHALL go to IDLE otherwise after the frame completes, with no wait for the remainder of the stop bit.
REQ-029 SHALL load rx_data, frame_err and parity_err together on frame completion; they stay stable while rx_valid is high.
REQ-030 SHALL clear rx_valid on the cycle after rx_valid and rx_ready are both high.
REQ-031 SHALL, on completion with rx_valid high and rx_ready low, keep the old data, discard the new frame and set overrun.
REQ-032 SHALL, on completion in the same cycle as rx_valid and rx_ready are both high, load the new frame, keep rx_valid high and leave overrun unchanged.
REQ-033 SHALL clear overrun only on a completed handshake (rx_valid and rx_ready high) or on reset.
REQ-034 SHALL, when enable is low, force the FSM to IDLE, aborting any partial frame, and leave rx_data, rx_valid and the flags untouched.

Reset
REQ-035 SHALL, on reset, immediately drive rx_data=0, rx_valid=0, busy=0, frame_err=0, parity_err=0, overrun=0, set the synchronisers to 1, clear the divider, and put the FSM in IDLE, including mid-frame.

Verification
Common bench setup: CLK_HZ=1600000, BAUD=10000, so DIV=10 and 160 cycles per bit.
REQ-036 SHALL check default framing: send 0xA5 8N1 with rx_ready=1 -> rx_data=0xA5, rx_valid pulses 1 cycle, no errors, busy low within 1 cycle of completion.
REQ-037 SHALL check glitch rejection: 40-cycle low pulse on idle line -> FSM back to IDLE, rx_valid stays 0, next frame 0x3C received correctly.
REQ-038 SHALL check parity: PARITY=1, send 0x07 with parity bit 0 -> parity_err=1, rx_data=0x07; same frame with parity bit 1 -> parity_err=0.
REQ-039 SHALL check framing and break: stop bit held 0 for 2 bit times -> frame_err=1, busy high until 16 high ticks seen, then a following 0x55 is received with frame_err=0.
REQ-040 SHALL check overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, overrun=1; raise rx_ready -> rx_valid and overrun clear next cycle.
REQ-041 SHALL check reset mid-frame: assert reset during data bit 3 -> all outputs 0 at once; after release, a full frame 0x81 is received correctly.
